// File: rtl/video_shifter.sv
// video_shifter: serialises 16-bit line buffer words into a 640-pixel monochrome scan line,
// MSB first, with the next word fetched while the current one shifts out.
module video_shifter (
  input  logic        CLK_I_25MHZ,
  input  logic        RSTN_I,
  input  logic        VEN_I,
  output logic [5:0]  LB_ADR_O,
  input  logic [15:0] LB_DAT_I,
  output logic        VIDEO_O,
  output logic        LINE_DONE_O
);
  typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;
  state_t      state;
  logic [15:0] shr;
  logic [3:0]  bc;
  logic [5:0]  wc;
  always_ff @(posedge CLK_I_25MHZ or negedge RSTN_I)
    if (!RSTN_I) begin
      state       <= IDLE;
      shr         <= '0;
      bc          <= '0;
      wc          <= '0;
      LINE_DONE_O <= 1'b0;
    end else if (!VEN_I) begin
      state       <= IDLE;
      shr         <= LB_DAT_I;
      bc          <= '0;
      wc          <= '0;
      LINE_DONE_O <= 1'b0;
    end else begin
      LINE_DONE_O <= 1'b0;
      case (state)
        IDLE: state <= ACTIVE;
        ACTIVE:
          if (bc != 4'd15) begin
            shr <= {shr[14:0], 1'b0};
            bc  <= bc + 4'd1;
          end else if (wc != 6'd39) begin
            shr <= LB_DAT_I;
            bc  <= '0;
            wc  <= wc + 6'd1;
          end else begin
            state       <= DONE;
            shr         <= '0;
            LINE_DONE_O <= 1'b1;
          end
        default: state <= state;
      endcase
    end
  // the next word is addressed for the whole current word so its data is ready at bc == 15
  always_comb begin
    VIDEO_O  = (state == ACTIVE) ? shr[15] : 1'b0;
    LB_ADR_O = (state == ACTIVE) ? wc + 6'd1 : 6'd0;
  end
endmodule

// File: tb/tb_video_shifter.sv
// tb_video_shifter: directed checks of video_shifter against a synchronous line buffer model.
module tb_video_shifter;
  logic        clk = 1'b0, rstn = 1'b0, ven = 1'b0;
  logic [5:0]  adr;
  logic [15:0] dat = '0;
  logic        video, done;
  int          n_vec = 0, n_err = 0, mode = 0;
  always #20 clk = ~clk;
  video_shifter dut (
    .CLK_I_25MHZ(clk), .RSTN_I(rstn), .VEN_I(ven), .LB_ADR_O(adr),
    .LB_DAT_I(dat), .VIDEO_O(video), .LINE_DONE_O(done)
  );
  function automatic logic [15:0] word(int m, logic [5:0] n);
    return (m == 1) ? 16'hFFFF : (m == 2) ? 16'hAAAA : {n, 10'b1000000001};
  endfunction
  always @(posedge clk) dat <= word(mode, adr);
  // word n = {n, 10'b1000000001}: bits 15..10 carry n, bit 9 and bit 0 are set
  function automatic logic pix(int m, int k);
    int b = k % 16;
    logic [5:0] n = 6'(k / 16);
    if (m == 1) return 1'b1;
    if (m == 2) return (b % 2) == 0;
    return (b < 6) ? n[5 - b] : (b == 6 || b == 15);
  endfunction
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic line(input int m, input int n_high);
    int pulses = 0;
    mode = m;
    ven = 1'b0;
    repeat (4) tick();
    chk("idle_adr", adr, 0);
    chk("idle_video", video, 0);
    ven = 1'b1;
    for (int i = 0; i < n_high; i++) begin
      tick();
      pulses += done;
      if (i < 640) begin
        chk($sformatf("m%0d_pix%0d", m, i), video, pix(m, i));
        chk($sformatf("m%0d_adr%0d", m, i), adr, i / 16 + 1);
        chk($sformatf("m%0d_done%0d", m, i), done, 0);
      end else begin
        chk($sformatf("m%0d_tail_video%0d", m, i), video, 0);
        chk($sformatf("m%0d_tail_adr%0d", m, i), adr, 0);
        chk($sformatf("m%0d_done_at%0d", m, i), done, i == 640);
      end
    end
    chk("pulse_count", pulses, n_high > 640);
    ven = 1'b0;
    tick();
    chk("drop_done", done, 0);
    chk("drop_video", video, 0);
    chk("drop_adr", adr, 0);
  endtask
  initial begin
    #5;
    chk("rst_video", video, 0);
    chk("rst_adr", adr, 0);
    chk("rst_done", done, 0);
    @(negedge clk);
    rstn = 1'b1;
    line(0, 641);
    line(0, 700);
    line(1, 641);
    line(2, 641);
    mode = 0;
    ven = 1'b0;
    repeat (4) tick();
    ven = 1'b1;
    repeat (100) tick();
    chk("abort_p99", video, pix(0, 99));
    ven = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("abort_gap_done", done, 0);
    end
    ven = 1'b1;
    tick();
    chk("abort_first", video, pix(0, 0));
    chk("abort_adr", adr, 1);
    chk("abort_done", done, 0);
    ven = 1'b0;
    repeat (4) tick();
    ven = 1'b1;
    repeat (322) tick();
    chk("pre_rst_video", video, pix(0, 321));
    chk("pre_rst_adr", adr, 21);
    #2 rstn = 1'b0;
    #1;
    chk("async_video", video, 0);
    chk("async_adr", adr, 0);
    chk("async_done", done, 0);
    #3 rstn = 1'b1;
    tick();
    chk("rearm_adr", adr, 1);
    chk("rearm_video", video, 0);
    ven = 1'b0;
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/video_shifter.md
VIDEO_SHIFTER -- requirements
Module: video_shifter

Interface
REQ-001 SHALL have port CLK_I_25MHZ, input, 1 bit: the single 25 MHz pixel clock; all state is updated on its rising edge.
REQ-002 SHALL have port RSTN_I, input, 1 bit: reset, asynchronous, active-low.
REQ-003 SHALL have port VEN_I, input, 1 bit: video enable; high while the 640 active pixels of a scan line are displayed.
REQ-004 SHALL have port LB_ADR_O, output, 6 bits: line buffer read address.
REQ-005 SHALL have port LB_DAT_I, input, 16 bits: line buffer read data; synchronous RAM, valid one clock after LB_ADR_O is sampled.
REQ-006 SHALL have port VIDEO_O, output, 1 bit: monochrome pixel (1 = lit).
REQ-007 SHALL have port LINE_DONE_O, output, 1 bit: one-cycle pulse when the 640th pixel of a line has been emitted.

Function
REQ-008 SHALL implement a 3-state FSM: IDLE, ACTIVE, DONE.
REQ-009 SHALL hold a 16-bit shift register SHR, a 4-bit bit counter BC and a 6-bit word counter WC.
REQ-010 IDLE: SHALL force BC=0 and WC=0, drive LB_ADR_O=0, and load SHR<=LB_DAT_I on every clock (word-0 preload).
REQ-011 IDLE->ACTIVE: SHALL occur on the first clock edge sampling VEN_I=1; no SHR load on that edge.
REQ-012 ACTIVE: SHALL drive VIDEO_O=SHR[15] combinationally, so pixel 0 appears in the first VEN_I-high cycle (zero latency).
REQ-013 ACTIVE: SHALL drive LB_ADR_O=WC+1 (6-bit).
REQ-014 ACTIVE with BC<15: each clock SHALL shift SHR left by one (LSB filled 0) and increment BC.
REQ-015 ACTIVE with BC=15 and WC<39: SHALL load SHR<=LB_DAT_I, set BC=0 and increment WC.
REQ-016 ACTIVE with BC=15 and WC=39: SHALL enter DONE, clear SHR and assert LINE_DONE_O on the same edge.
REQ-017 Pixel k (0..639) of a line SHALL equal bit 15-(k mod 16) of line buffer word floor(k/16): MSB first, words in ascending order.
REQ-018 DONE: VIDEO_O=0, LB_ADR_O=0, counters held; SHALL remain in DONE while VEN_I=1.
REQ-019 LINE_DONE_O SHALL be registered, high for exactly the first cycle in DONE, and otherwise 0.
REQ-020 From any state, a clock edge sampling VEN_I=0 SHALL enter IDLE and clear BC and WC. SHR SHALL be reloaded per REQ-010, and LINE_DONE_O SHALL be 0.
REQ-021 VEN_I falling mid-line SHALL abort the line without a LINE_DONE_O pulse; the next VEN_I rise restarts at word 0 bit 15.
REQ-022 VIDEO_O SHALL be 0 in IDLE and DONE regardless of SHR contents.
REQ-023 Correct pixel 0 requires VEN_I low for at least 2 clocks before the line; shorter gaps are a system error with undefined pixel 0..15 content only.

Reset
REQ-024 RSTN_I=0 SHALL immediately, without a clock, force state IDLE, SHR=0, BC=0 and WC=0.
REQ-025 RSTN_I=0 SHALL immediately force VIDEO_O=0, LB_ADR_O=0 and LINE_DONE_O=0.
REQ-026 Deassertion of RSTN_I SHALL take effect on the next rising clock; behaviour then follows REQ-010/011.

Verification
REQ-027 Full line: LB word n = {n[5:0],10'b1000000001}, VEN_I low 4 cycles then high 640 -> VIDEO_O matches REQ-017 for all 640 pixels; LINE_DONE_O=1 only in cycle 640 after rise.
REQ-028 Address trace: during pixels 16n..16n+15, LB_ADR_O=n+1; during IDLE and DONE, LB_ADR_O=0.
REQ-029 Overlong enable: VEN_I high 700 cycles -> cycles 640..699 VIDEO_O=0; exactly one LINE_DONE_O pulse.
REQ-030 Abort: VEN_I drops after pixel 99, low 2 cycles, high again -> no LINE_DONE_O; first new pixel = word 0 bit 15.
REQ-031 Async reset: RSTN_I pulsed low mid-word 20 between clock edges -> all outputs 0 before the next edge; with VEN_I still high, ACTIVE re-entered on the first edge after release.
REQ-032 Patterns: all-ones words -> VIDEO_O=1 for 640 contiguous cycles; alternating 16'hAAAA -> VIDEO_O toggles every cycle starting at 1, with no glitch at word boundaries.
